// File: rtl/shared_pkg.sv
// Shared definitions for the user-request FIFO and its read-side controller.
package shared_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER} rd_state_e;

  localparam int FIFO_WIDTH = 16;
  localparam int BURST_LEN  = 4;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry prefetch buffer that hides the FIFO read latency; head entry is o_data.
module reader_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // simultaneous push/pop keeps occupancy; new word lands behind the survivor
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/req_fifo_reader.sv
// Read-side controller: requests the server, then pops and delivers one fixed-length burst.
// state | meaning
// IDLE  | waiting for the FIFO to hold data
// REQ   | srv_req high, waiting for a grant
// XFER  | popping and delivering BURST_LEN words
module req_fifo_reader #(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int BURST_LEN  = shared_pkg::BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  srv_req,
  input  logic                  srv_gnt,
  output logic                  srv_valid,
  output logic [FIFO_WIDTH-1:0] srv_data,
  output logic                  srv_last,
  input  logic                  srv_ready,
  output logic                  busy
);
  import shared_pkg::*;

  localparam logic [7:0] LP_BURST = 8'(BURST_LEN);

  rd_state_e  r_state;
  logic [7:0] r_issued;
  logic [7:0] r_sent;
  logic       r_rd_pend;

  logic [1:0] w_count;
  logic [2:0] w_occ;
  logic       w_hs;
  logic       w_rd_en;

  reader_skid_buf #(.WIDTH(FIFO_WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_pend),
    .i_pop   (w_hs),
    .i_data  (fifo_data_out),
    .o_data  (srv_data),
    .o_count (w_count)
  );

  // occupancy counts the read still in flight so the buffer can never overflow
  assign w_occ     = {1'b0, w_count} + {2'b00, r_rd_pend};
  assign srv_valid = (w_count != 2'd0);
  assign w_hs      = srv_valid && srv_ready;
  assign srv_last  = srv_valid && (r_sent == LP_BURST - 8'd1);
  assign w_rd_en   = rst_n && (r_state == XFER) && !fifo_empty &&
                     (r_issued < LP_BURST) && ((w_occ < 3'd2) || w_hs);
  assign fifo_rd_en = w_rd_en;
  assign srv_req    = (r_state == REQ);
  assign busy       = (r_state == REQ) || (r_state == XFER);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_issued  <= '0;
      r_sent    <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_en;
      case (r_state)
        IDLE: if (!fifo_empty) r_state <= REQ;
        REQ: begin
          if (srv_gnt) begin
            r_state  <= XFER;
            r_issued <= '0;
            r_sent   <= '0;
          end
        end
        XFER: begin
          if (w_rd_en) r_issued <= r_issued + 8'd1;
          if (w_hs) begin
            r_sent <= r_sent + 8'd1;
            if (srv_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
